mac_operand_feeder: RTL and testbench

- Upstream stage of the int/fp MAC: buffers independent A and B operand streams in two FIFOs.
- Issues one configuration sequence per vector: config_en, float_int, data_num.
- Then streams aligned A/B pairs, with both valids asserted in the same cycle, so the MAC always sees complete pairs.
- Counts issued pairs against the configured vector length and signals vector completion.

---
 rtl/mac_operand_feeder.sv | 172 +++++++++++++++++
 tb/tb_mac_operand_feeder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_feeder.sv
// Operand feeder for the int/fp MAC.
// A and B operands are buffered in two independent FIFOs. Each vector starts
// with a two-cycle configuration strobe. After that, the A and B FIFO heads
// are issued together as one pair, so the MAC never sees half a pair. The
// block counts issued pairs against the requested length and pulses vec_done
// once the vector is complete.
module mac_operand_feeder #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_req,
    input  logic        cfg_float_int,
    input  logic [7:0]  cfg_len,
    output logic        cfg_ack,
    input  logic [15:0] a_data,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [15:0] b_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic        hold,
    output logic [15:0] out_a,
    output logic [15:0] out_b,
    output logic        out_valid_a,
    output logic        out_valid_b,
    output logic        config_en,
    output logic        float_int,
    output logic [7:0]  data_num,
    output logic        vec_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        CONF1,
        CONF2,
        RUN,
        DONE
    } state_t;

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    state_t        state;
    logic [15:0]   mem_a [DEPTH];
    logic [15:0]   mem_b [DEPTH];
    logic [AW-1:0] wp_a, rp_a, wp_b, rp_b;
    logic [AW:0]   cnt_a, cnt_b;
    logic [8:0]    pair_cnt;
    logic [8:0]    target;
    logic          push_a, push_b;
    logic          issue;

    // Ready comes from the registered counts only. It is also held low while
    // reset is asserted, so every output reads 0 during reset.
    assign a_ready = rst_n && (cnt_a != FULL_CNT);
    assign b_ready = rst_n && (cnt_b != FULL_CNT);
    assign push_a  = a_valid && a_ready;
    assign push_b  = b_valid && b_ready;

    // A pair leaves only when both heads exist, so the two streams stay aligned.
    assign issue = (state == RUN) && (cnt_a != '0) && (cnt_b != '0) && !hold;

    // Operand storage: written on push and read at the head on issue.
    // NOTE: the storage arrays have no reset. Entries are only read once the
    // counts say they are valid, so clearing them would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push_a) mem_a[wp_a] <= a_data;
        if (push_b) mem_b[wp_b] <= b_data;
    end

    // A FIFO pointers and occupancy. The pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_a  <= '0;
            rp_a  <= '0;
            cnt_a <= '0;
        end else begin
            if (push_a) wp_a <= wp_a + 1'b1;
            if (issue)  rp_a <= rp_a + 1'b1;
            case ({push_a, issue})
                2'b10:   cnt_a <= cnt_a + 1'b1;
                2'b01:   cnt_a <= cnt_a - 1'b1;
                default: cnt_a <= cnt_a;
            endcase
        end
    end

    // B FIFO pointers and occupancy. This mirrors the A side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_b  <= '0;
            rp_b  <= '0;
            cnt_b <= '0;
        end else begin
            if (push_b) wp_b <= wp_b + 1'b1;
            if (issue)  rp_b <= rp_b + 1'b1;
            case ({push_b, issue})
                2'b10:   cnt_b <= cnt_b + 1'b1;
                2'b01:   cnt_b <= cnt_b - 1'b1;
                default: cnt_b <= cnt_b;
            endcase
        end
    end

    // Vector sequencer. Every MAC-facing output is registered here.
    // NOTE: state is updated with non-blocking assignments. Each decision
    // therefore uses the values from before the edge, just like real flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cfg_ack     <= 1'b0;
            config_en   <= 1'b0;
            float_int   <= 1'b0;
            data_num    <= '0;
            target      <= '0;
            pair_cnt    <= '0;
            out_a       <= '0;
            out_b       <= '0;
            out_valid_a <= 1'b0;
            out_valid_b <= 1'b0;
            vec_done    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            cfg_ack     <= 1'b0;
            vec_done    <= 1'b0;
            out_valid_a <= 1'b0;
            out_valid_b <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_req) begin
                        float_int <= cfg_float_int;
                        data_num  <= cfg_len;
                        target    <= (cfg_len == 8'd0) ? 9'd256 : {1'b0, cfg_len};
                        pair_cnt  <= '0;
                        cfg_ack   <= 1'b1;
                        config_en <= 1'b1;
                        busy      <= 1'b1;
                        state     <= CONF1;
                    end
                end
                CONF1: begin
                    state <= CONF2;
                end
                CONF2: begin
                    config_en <= 1'b0;
                    state     <= RUN;
                end
                RUN: begin
                    if (issue) begin
                        out_a       <= mem_a[rp_a];
                        out_b       <= mem_b[rp_b];
                        out_valid_a <= 1'b1;
                        out_valid_b <= 1'b1;
                        pair_cnt    <= pair_cnt + 9'd1;
                        if (pair_cnt + 9'd1 == target) state <= DONE;
                    end
                end
                DONE: begin
                    vec_done <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Testbench for mac_operand_feeder. A queue-based reference model predicts
// every output on every cycle. Directed sequences also pin the expected pair
// values, the strobe widths and the corner cases with hand-written constants.
module tb_mac_operand_feeder;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cfg_req = 1'b0;
    logic        cfg_float_int = 1'b0;
    logic [7:0]  cfg_len = '0;
    logic [15:0] a_data = '0;
    logic        a_valid = 1'b0;
    logic [15:0] b_data = '0;
    logic        b_valid = 1'b0;
    logic        hold = 1'b0;
    logic        cfg_ack, a_ready, b_ready;
    logic [15:0] out_a, out_b;
    logic        out_valid_a, out_valid_b, config_en, float_int, vec_done, busy;
    logic [7:0]  data_num;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    mac_operand_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_req(cfg_req), .cfg_float_int(cfg_float_int), .cfg_len(cfg_len),
        .cfg_ack(cfg_ack),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .hold(hold),
        .out_a(out_a), .out_b(out_b),
        .out_valid_a(out_valid_a), .out_valid_b(out_valid_b),
        .config_en(config_en), .float_int(float_int), .data_num(data_num),
        .vec_done(vec_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    bit          m_active = 1'b0;
    int          m_conf = 0;
    int          m_left = 0;
    bit          m_pa, m_pb, m_iss;
    logic        e_ack = 1'b0, e_va = 1'b0, e_done = 1'b0, e_fi = 1'b0;
    logic [7:0]  e_dn = '0;
    logic [15:0] e_a = '0, e_b = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            m_active = 1'b0; m_conf = 0; m_left = 0;
            e_ack = 1'b0; e_va = 1'b0; e_done = 1'b0; e_fi = 1'b0;
            e_dn = '0; e_a = '0; e_b = '0;
        end else begin
            m_pa  = a_valid && (qa.size() < DEPTH);
            m_pb  = b_valid && (qb.size() < DEPTH);
            m_iss = m_active && m_conf == 0 && m_left > 0 &&
                    qa.size() > 0 && qb.size() > 0 && !hold;
            e_ack = 1'b0; e_va = 1'b0; e_done = 1'b0;
            if (!m_active) begin
                if (cfg_req) begin
                    m_active = 1'b1;
                    m_conf   = 2;
                    m_left   = (cfg_len == 0) ? 256 : int'(cfg_len);
                    e_fi     = cfg_float_int;
                    e_dn     = cfg_len;
                    e_ack    = 1'b1;
                end
            end else if (m_conf > 0) begin
                m_conf--;
            end else if (m_left > 0) begin
                if (m_iss) begin
                    e_a  = qa.pop_front();
                    e_b  = qb.pop_front();
                    e_va = 1'b1;
                    m_left--;
                end
            end else begin
                e_done   = 1'b1;
                m_active = 1'b0;
            end
            if (m_pa) qa.push_back(a_data);
            if (m_pb) qb.push_back(b_data);
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (cmp_en)
            check("outputs",
                  {cfg_ack, a_ready, b_ready, out_a, out_b, out_valid_a, out_valid_b,
                   config_en, float_int, data_num, vec_done, busy},
                  {e_ack, rst_n && (qa.size() < DEPTH), rst_n && (qb.size() < DEPTH),
                   e_a, e_b, e_va, e_va, m_active && (m_conf > 0), e_fi, e_dn,
                   e_done, m_active});
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic pair_chk(input string name, input logic [15:0] a, input logic [15:0] b);
        check(name, {out_valid_a, out_valid_b, out_a, out_b}, {2'b11, a, b});
    endtask

    task automatic none_chk(input string name);
        check(name, {out_valid_a, out_valid_b}, 2'b00);
    endtask

    task automatic start_vec(input logic [7:0] len, input logic fi);
        cfg_req = 1'b1; cfg_len = len; cfg_float_int = fi;
        cyc();
        check("cfg_ack_pulse", {cfg_ack, config_en, busy}, 3'b111);
        check("data_num", {float_int, data_num}, {fi, len});
        cfg_req = 1'b0;
        cyc();
        check("config_en_2nd", {cfg_ack, config_en}, 2'b01);
        cyc();
        check("config_en_off", {config_en, busy}, 2'b01);
    endtask

    int seen;

    initial begin
        #2 rst_n = 1'b0;
        cyc();
        cyc();
        check("reset_outputs",
              {cfg_ack, a_ready, b_ready, out_a, out_b, out_valid_a, out_valid_b,
               config_en, float_int, data_num, vec_done, busy}, 64'd0);
        cmp_en = 1'b1;
        rst_n = 1'b1;
        cyc();
        check("ready_after_reset", {a_ready, b_ready, busy}, 3'b110);

        // Basic three-pair vector
        start_vec(8'd3, 1'b0);
        a_valid = 1'b1; b_valid = 1'b1; a_data = 16'd1; b_data = 16'd4;
        cyc(); none_chk("latency_first_push");
        a_data = 16'd2; b_data = 16'd5;
        cyc(); pair_chk("pair_1_4", 16'd1, 16'd4);
        a_data = 16'd3; b_data = 16'd6;
        cyc(); pair_chk("pair_2_5", 16'd2, 16'd5);
        a_valid = 1'b0; b_valid = 1'b0;
        cyc(); pair_chk("pair_3_6", 16'd3, 16'd6);
        cyc(); check("vec_done_3", {vec_done, busy, out_valid_a}, 3'b100);
        cyc(); check("vec_done_clear", vec_done, 1'b0);

        // Skewed streams: A arrives first, B five cycles later
        start_vec(8'd2, 1'b0);
        a_valid = 1'b1; a_data = 16'd7;
        cyc(); a_data = 16'd8;
        cyc(); a_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(); none_chk("a_only_waits");
        end
        b_valid = 1'b1; b_data = 16'd9;
        cyc(); none_chk("b_push_edge");
        b_data = 16'd10;
        cyc(); pair_chk("pair_7_9", 16'd7, 16'd9);
        b_valid = 1'b0;
        cyc(); pair_chk("pair_8_10", 16'd8, 16'd10);
        cyc(); check("vec_done_skew", vec_done, 1'b1);

        // Full A FIFO, filled while idle
        a_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_data = 16'(20 + i);
            cyc();
        end
        check("a_full", a_ready, 1'b0);
        a_data = 16'd99;
        cyc(); check("a_full_drop", a_ready, 1'b0);
        a_valid = 1'b0;
        start_vec(8'd1, 1'b1);
        b_valid = 1'b1; b_data = 16'd50;
        cyc(); b_valid = 1'b0;
        cyc(); pair_chk("pair_20_50", 16'd20, 16'd50);
        check("a_ready_back", a_ready, 1'b1);
        cyc(); check("vec_done_full", vec_done, 1'b1);

        // Hold for four cycles with data present
        start_vec(8'd4, 1'b0);
        hold = 1'b1; b_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_data = 16'(60 + i);
            cyc(); none_chk("hold_blocks");
        end
        hold = 1'b0; b_valid = 1'b0;
        cyc(); pair_chk("resume_21_60", 16'd21, 16'd60);
        cyc(); pair_chk("pair_22_61", 16'd22, 16'd61);
        cyc(); pair_chk("pair_23_62", 16'd23, 16'd62);
        cyc(); pair_chk("pair_24_63", 16'd24, 16'd63);
        cyc(); check("vec_done_hold", vec_done, 1'b1);

        // Reset after two of five pairs
        start_vec(8'd5, 1'b1);
        b_valid = 1'b1; b_data = 16'd70;
        cyc(); b_data = 16'd71;
        cyc(); pair_chk("pair_25_70", 16'd25, 16'd70);
        b_valid = 1'b0;
        cyc(); pair_chk("pair_26_71", 16'd26, 16'd71);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs",
              {cfg_ack, a_ready, b_ready, out_a, out_b, out_valid_a, out_valid_b,
               config_en, float_int, data_num, vec_done, busy}, 64'd0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); check("no_done_after_abort", {vec_done, busy, a_ready, b_ready}, 4'b0011);
        end

        // 256-pair vector with pointer wrap and a cfg_req ignored during RUN
        start_vec(8'd0, 1'b0);
        seen = 0;
        for (int i = 0; i < 256; i++) begin
            a_valid = 1'b1; b_valid = 1'b1;
            a_data = 16'(i); b_data = 16'(16'h1000 + i);
            cfg_req = (i >= 5 && i < 15); cfg_float_int = (i >= 5 && i < 15);
            cyc();
            if (i >= 5 && i < 15) check("cfg_req_ignored", {cfg_ack, float_int}, 2'b00);
            if (out_valid_a) begin
                pair_chk("wrap_pair", 16'(seen), 16'(16'h1000 + seen));
                seen++;
            end
        end
        a_valid = 1'b0; b_valid = 1'b0; cfg_req = 1'b0; cfg_float_int = 1'b0;
        cyc();
        if (out_valid_a) seen++;
        pair_chk("last_pair_255", 16'd255, 16'h10ff);
        check("pairs_256", seen, 256);
        cyc(); check("vec_done_256", {vec_done, busy, float_int}, 3'b100);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
